// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard: per-stage in-flight record
// and forwarding select encodings.
package hazard_pkg;

   localparam int MAX_FWD_STAGES = 4;

   localparam logic [2:0] FWD_RF  = 3'd0;
   localparam logic [2:0] FWD_EXE = 3'd1;
   localparam logic [2:0] FWD_MEM = 3'd2;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wreg;
      logic       load;
   } hz_rec_t;

   localparam hz_rec_t HZ_REC_EMPTY = '0;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for the hazard scoreboard: ID operand/destination fields in,
// forwarding selects and pipeline stall/bubble/hold controls out.
interface hazard_scoreboard_if;

   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_use_rs1;
   logic       id_use_rs2;
   logic [4:0] id_rd;
   logic       id_wreg;
   logic       id_m2reg;
   logic       id_is_div;
   logic       ex_redirect;

   logic [2:0] qa_sel;
   logic [2:0] qb_sel;
   logic       pc_stall;
   logic       ifid_stall;
   logic       inst_nop;
   logic       ex_hold;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_wreg, id_m2reg, id_is_div, ex_redirect,
      input  qa_sel, qb_sel, pc_stall, ifid_stall, inst_nop, ex_hold
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_wreg, id_m2reg, id_is_div, ex_redirect,
      output qa_sel, qb_sel, pc_stall, ifid_stall, inst_nop, ex_hold
   );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Priority match of one source register against the in-flight records; the youngest
// matching stage decides both the forward select and whether the data is ready yet.
module hazard_match
   import hazard_pkg::*;
#(
   parameter int FWD_STAGES = 2,
   parameter int LOAD_STAGE = 2
) (
   input  logic [4:0] src_i,
   input  logic       use_i,
   input  hz_rec_t    recs_i [FWD_STAGES],
   output logic [2:0] sel_o,
   output logic       notReady_o
);

   logic found;

   // Older matches are shadowed once a younger one is found; a load still short of
   // LOAD_STAGE blocks forwarding rather than letting an older stage supply stale data.
   always_comb begin
      sel_o      = FWD_RF;
      notReady_o = 1'b0;
      found      = 1'b0;
      for (int k = 0; k < FWD_STAGES; k++) begin
         if (!found && use_i && (src_i != 5'd0) && recs_i[k].valid &&
             recs_i[k].wreg && (recs_i[k].rd == src_i)) begin
            found = 1'b1;
            if (recs_i[k].load && ((k + 1) < LOAD_STAGE)) begin
               notReady_o = 1'b1;
            end else begin
               sel_o = 3'(k + 1);
            end
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Clocked hazard/forwarding scoreboard beside decode. Define HAZARD_DIV_EN to add the
// multi-cycle divider hold on EXE; without it ex_hold is tied low and id_is_div ignored.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int FWD_STAGES = 2,
   parameter int LOAD_STAGE = 2,
   parameter int DIV_LAT    = 4
) (
   input  logic                clk,
   input  logic                rst,
   hazard_scoreboard_if.slave  hif
);

   hz_rec_t rec_q [FWD_STAGES];
   hz_rec_t rec_d [FWD_STAGES];

   logic notReadyA;
   logic notReadyB;
   logic holdActive;
   logic redirectEff;
   logic dataStall;
   logic issue;

   hazard_match #(.FWD_STAGES(FWD_STAGES), .LOAD_STAGE(LOAD_STAGE)) matchA (
      .src_i      (hif.id_rs1),
      .use_i      (hif.id_use_rs1),
      .recs_i     (rec_q),
      .sel_o      (hif.qa_sel),
      .notReady_o (notReadyA)
   );

   hazard_match #(.FWD_STAGES(FWD_STAGES), .LOAD_STAGE(LOAD_STAGE)) matchB (
      .src_i      (hif.id_rs2),
      .use_i      (hif.id_use_rs2),
      .recs_i     (rec_q),
      .sel_o      (hif.qb_sel),
      .notReady_o (notReadyB)
   );

   // A divider occupying EXE cannot branch, so its hold masks any redirect.
   assign redirectEff = hif.ex_redirect & ~holdActive;
   assign dataStall   = hif.id_valid & (notReadyA | notReadyB);
   assign issue       = hif.id_valid & ~dataStall & ~redirectEff;

   always_comb begin
      hif.pc_stall   = 1'b0;
      hif.ifid_stall = 1'b0;
      hif.inst_nop   = 1'b0;
      hif.ex_hold    = holdActive;
      if (holdActive) begin
         hif.pc_stall   = 1'b1;
         hif.ifid_stall = 1'b1;
      end else if (redirectEff) begin
         hif.inst_nop = 1'b1;
      end else if (dataStall) begin
         hif.pc_stall   = 1'b1;
         hif.ifid_stall = 1'b1;
         hif.inst_nop   = 1'b1;
      end
   end

   // Records advance one stage per cycle; stalled or wrong-path instructions enter as bubbles.
   always_comb begin
      rec_d = rec_q;
      if (!holdActive) begin
         for (int k = FWD_STAGES - 1; k > 0; k--) begin
            rec_d[k] = rec_q[k-1];
         end
         rec_d[0] = HZ_REC_EMPTY;
         if (issue) begin
            rec_d[0].valid = 1'b1;
            rec_d[0].rd    = hif.id_rd;
            rec_d[0].wreg  = hif.id_wreg;
            rec_d[0].load  = hif.id_m2reg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rec_q <= '{default: HZ_REC_EMPTY};
      end else begin
         rec_q <= rec_d;
      end
   end

`ifdef HAZARD_DIV_EN
   localparam int DivW = $clog2(DIV_LAT) + 1;

   logic [DivW-1:0] divCnt_q;
   logic [DivW-1:0] divCnt_d;

   assign holdActive = (divCnt_q != '0);

   // The entry cycle counts toward occupancy, so the counter starts one short of DIV_LAT.
   always_comb begin
      divCnt_d = '0;
      if (holdActive) begin
         divCnt_d = divCnt_q - 1'b1;
      end else if (issue && hif.id_is_div) begin
         divCnt_d = DivW'(DIV_LAT - 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         divCnt_q <= '0;
      end else begin
         divCnt_q <= divCnt_d;
      end
   end
`else
   logic unusedDiv;

   assign holdActive = 1'b0;
   assign unusedDiv  = hif.id_is_div ^ DIV_LAT[0];
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard: stimulus pushes expected outputs into a
// queue, an independent monitor pops and compares them mid-cycle.
module tb_hazard_scoreboard;

   typedef struct {
      string      name;
      logic [2:0] qa;
      logic [2:0] qb;
      logic       stall;
      logic       nop;
      logic       hold;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   exp_t expQ[$];
   int   totalChecks = 0;
   int   badChecks   = 0;

   hazard_scoreboard_if hif();

   hazard_scoreboard #(.FWD_STAGES(2), .LOAD_STAGE(2), .DIV_LAT(4)) dut (
      .clk (clk),
      .rst (rst),
      .hif (hif)
   );

   always #5 clk = ~clk;

   // Drive one ID cycle just after the edge and queue what the outputs must be in it.
   task automatic applyStimulus(
      input string name, input bit r, input bit v,
      input int rs1, input int rs2, input bit u1, input bit u2,
      input int rd, input bit w, input bit ld, input bit dv, input bit redir,
      input int qa, input int qb, input bit stall, input bit nop, input bit hold);
      exp_t e;
      @(posedge clk);
      #1;
      rst             = r;
      hif.id_valid    = v;
      hif.id_rs1      = 5'(rs1);
      hif.id_rs2      = 5'(rs2);
      hif.id_use_rs1  = u1;
      hif.id_use_rs2  = u2;
      hif.id_rd       = 5'(rd);
      hif.id_wreg     = w;
      hif.id_m2reg    = ld;
      hif.id_is_div   = dv;
      hif.ex_redirect = redir;
      e.name  = name;
      e.qa    = 3'(qa);
      e.qb    = 3'(qb);
      e.stall = stall;
      e.nop   = nop;
      e.hold  = hold;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      logic [9:0] got;
      logic [9:0] want;
      got  = {hif.qa_sel, hif.qb_sel, hif.pc_stall, hif.ifid_stall, hif.inst_nop, hif.ex_hold};
      want = {e.qa, e.qb, e.stall, e.stall, e.nop, e.hold};
      totalChecks++;
      if (got !== want) begin
         badChecks++;
         $display("[TB] FAIL %s got qa=%0d qb=%0d pc=%0b ifid=%0b nop=%0b hold=%0b want qa=%0d qb=%0d pc=%0b ifid=%0b nop=%0b hold=%0b",
                  e.name, hif.qa_sel, hif.qb_sel, hif.pc_stall, hif.ifid_stall, hif.inst_nop,
                  hif.ex_hold, e.qa, e.qb, e.stall, e.stall, e.nop, e.hold);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      hif.id_valid    = 1'b0;
      hif.id_rs1      = '0;
      hif.id_rs2      = '0;
      hif.id_use_rs1  = 1'b0;
      hif.id_use_rs2  = 1'b0;
      hif.id_rd       = '0;
      hif.id_wreg     = 1'b0;
      hif.id_m2reg    = 1'b0;
      hif.id_is_div   = 1'b0;
      hif.ex_redirect = 1'b0;

      //              name                 r v rs1 rs2 u1 u2 rd w ld dv rd  qa qb st nop hd
      applyStimulus("reset_a",             1,0, 0, 0, 0,0, 0,0,0,0,0,  0,0,0,0,0);
      applyStimulus("reset_b",             1,0, 0, 0, 0,0, 0,0,0,0,0,  0,0,0,0,0);
      applyStimulus("add_x5",              0,1, 1, 2, 1,1, 5,1,0,0,0,  0,0,0,0,0);
      applyStimulus("sub_fwd_exe",         0,1, 5, 3, 1,1, 6,1,0,0,0,  1,0,0,0,0);
      applyStimulus("or_fwd_both",         0,1, 5, 6, 1,1, 7,1,0,0,0,  2,1,0,0,0);
      applyStimulus("lw_x7",               0,1, 1, 0, 1,0, 7,1,1,0,0,  0,0,0,0,0);
      applyStimulus("load_use_stall",      0,1, 7, 7, 1,1, 8,1,0,0,0,  0,0,1,1,0);
      applyStimulus("load_use_fwd_mem",    0,1, 7, 7, 1,1, 8,1,0,0,0,  2,2,0,0,0);
      applyStimulus("addi_x0",             0,1, 0, 0, 1,0, 0,1,0,0,0,  0,0,0,0,0);
      applyStimulus("x0_no_fwd",           0,1, 0, 0, 1,1, 9,1,0,0,0,  0,0,0,0,0);
      applyStimulus("unused_src",          0,1, 9, 8, 0,0,10,1,0,0,0,  0,0,0,0,0);
      applyStimulus("lw_x12",              0,1,10, 0, 1,0,12,1,1,0,0,  1,0,0,0,0);
      applyStimulus("redirect_over_stall", 0,1,12, 0, 1,1,13,1,0,0,1,  0,0,0,1,0);
      applyStimulus("wrong_path_dropped",  0,1,13,12, 1,1,15,1,0,0,0,  0,2,0,0,0);
      applyStimulus("redirect_plain",      0,1,15, 0, 1,1,16,1,0,0,1,  1,0,0,1,0);
      applyStimulus("after_redirect",      0,1,16,15, 1,1,17,1,0,0,0,  0,2,0,0,0);
      applyStimulus("lw_x20",              0,1, 0, 0, 0,0,20,1,1,0,0,  0,0,0,0,0);
      applyStimulus("reset_mid",           1,0,20,20, 0,0, 0,0,0,0,0,  0,0,0,0,0);
      applyStimulus("after_reset",         0,1,20,20, 1,1,21,1,0,0,0,  0,0,0,0,0);
`ifdef HAZARD_DIV_EN
      applyStimulus("div_issue",           0,1, 1, 2, 1,1,10,1,0,1,0,  0,0,0,0,0);
      applyStimulus("div_hold1",           0,1,10, 0, 1,1,11,1,0,0,0,  1,0,1,0,1);
      applyStimulus("div_hold2_redir",     0,1,10, 0, 1,1,11,1,0,0,1,  1,0,1,0,1);
      applyStimulus("div_hold3",           0,1,10, 0, 1,1,11,1,0,0,0,  1,0,1,0,1);
      applyStimulus("div_done_fwd",        0,1,10, 0, 1,1,11,1,0,0,0,  1,0,0,0,0);
      applyStimulus("div2_issue",          0,1, 0, 0, 0,0,10,1,0,1,0,  0,0,0,0,0);
      applyStimulus("div2_hold1",          0,0, 0, 0, 0,0, 0,0,0,0,0,  0,0,1,0,1);
      applyStimulus("div2_rst",            1,0, 0, 0, 0,0, 0,0,0,0,0,  0,0,1,0,1);
      applyStimulus("div2_after_rst",      0,1,10, 0, 1,1,11,1,0,0,0,  0,0,0,0,0);
`else
      applyStimulus("div_ignored_issue",   0,1, 1, 2, 1,1,10,1,0,1,0,  0,0,0,0,0);
      applyStimulus("div_ignored_fwd",     0,1,10, 0, 1,1,11,1,0,0,0,  1,0,0,0,0);
`endif
      applyStimulus("idle_tail",           0,0, 0, 0, 0,0, 0,0,0,0,0,  0,0,0,0,0);

      for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
         @(posedge clk);
      end
      if (expQ.size() != 0) begin
         totalChecks++;
         badChecks++;
         $display("[TB] FAIL drain_timeout pending=%0d want pending=0", expQ.size());
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the RISC-V pipeline. It replaces the fixed two-source forwarding and stall logic in the decode controller with a clocked scoreboard of in-flight destination registers across FWD_STAGES downstream stages. It handles configurable load latency, redirect flushes from EXE and an optional multi-cycle divider hold. It sits beside decode: it consumes ID operand and destination fields and drives the forwarding muxes, the PC/IFID stall enables and the bubble select.

## Interface
- FWD_STAGES, 2: number of tracked stages after ID (1 = EXE, 2 = MEM, …); range 1..4
- LOAD_STAGE, 2: first stage index at which load data can be forwarded; range 1..FWD_STAGES
- DIV_LAT, 4: divider occupancy of EXE in cycles (only with HAZARD_DIV_EN); at least 2

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  5  source register fields
- id_use_rs1, id_use_rs2  in  1  the instruction actually reads rs1/rs2
- id_rd  in  5  destination register
- id_wreg  in  1  the instruction writes rd
- id_m2reg  in  1  the instruction is a load
- id_is_div  in  1  the instruction is a divide/remainder (ignored without macro)
- ex_redirect  in  1  branch taken or jump resolved in EXE this cycle
- qa_sel, qb_sel  out  3  0 = register file, k = forward from stage k
- pc_stall, ifid_stall  out  1  hold PC / IFID register
- inst_nop  out  1  inject a bubble into EXE instead of the ID instruction
- ex_hold  out  1  EXE is occupied by the divider; EXE/MEM registers must not advance

## Operation
- Scoreboard: FWD_STAGES records {valid, rd, wreg, load}, where rec[1] is EXE. Each cycle without ex_hold:
  - rec[k+1] ← rec[k]
  - rec[1] ← ID fields when id_valid and no stall and no redirect; otherwise rec[1] ← invalid (bubble)
- Match for source s at stage k: rec[k].valid, rec[k].wreg, rec[k].rd == s, and s != 0. The youngest (lowest k) match wins.
- Ready: a match is ready unless rec[k].load and k < LOAD_STAGE.
- Forwarding: qX_sel = k of the winning ready match, otherwise 0. It is forced to 0 when id_use_rsX = 0.
- Data stall: id_valid, a source in use, and its youngest match is not ready. Outputs: pc_stall = ifid_stall = inst_nop = 1.
- Redirect: ex_redirect = 1 gives inst_nop = 1 and pc_stall = ifid_stall = 0, so the PC loads the target. Redirect beats a data stall. The wrong-path ID instruction never enters rec[1].
- Hold: when ex_hold = 1, records do not shift, pc_stall = ifid_stall = 1 and inst_nop = 0. Redirect is ignored while ex_hold is set, because the divider in EXE cannot branch.
- Matches beyond FWD_STAGES rely on the register file writing through; no stall is generated for them.

## Timing
- All outputs are combinational from the current records, the ID inputs and ex_redirect. State updates on the rising edge of clk.
- Load-use penalty is LOAD_STAGE − 1 cycles when the consumer immediately follows the load.
- Divider: a div entering rec[1] loads div_cnt ← DIV_LAT − 1. ex_hold = (div_cnt != 0), and div_cnt decrements each cycle. The EXE occupancy is therefore DIV_LAT cycles total.
- Reset: all records invalid, div_cnt = 0. Reset outputs are qa_sel = qb_sel = 0 and pc_stall = ifid_stall = inst_nop = ex_hold = 0, given id_valid = 0 and ex_redirect = 0.
- Reset mid-divide: records and div_cnt clear on the next edge, and ex_hold drops in the same cycle the edge is taken.

## Configuration
- HAZARD_DIV_EN defined: id_is_div, div_cnt and ex_hold logic are present.
- HAZARD_DIV_EN undefined: id_is_div is ignored, ex_hold is tied to 0 and DIV_LAT is unused.

## Structure
- hazard_pkg holds:
  - typedef hz_rec_t {valid, rd, wreg, load}
  - constants FWD_RF = 0, FWD_EXE = 1, FWD_MEM = 2
  - MAX_FWD_STAGES = 4
- One sub-module, hazard_match: per-source priority match over the records. It returns the select value and a not-ready flag, and is instantiated once each for rs1 and rs2.

## Test plan
- `add x5,x1,x2` then `sub x6,x5,x3` → qa_sel = 1 in the sub's ID cycle, no stall.
- `lw x7,0(x1)` then `add x8,x7,x7` with LOAD_STAGE = 2 → one cycle with pc_stall = ifid_stall = inst_nop = 1, then qa_sel = qb_sel = 2.
- `addi x0,x0,5` then `add x9,x0,x0` → qa_sel = qb_sel = 0, no stall.
- Load-use stall cycle with ex_redirect = 1 in the same cycle → inst_nop = 1, pc_stall = 0, rec[1] invalid next cycle.
- HAZARD_DIV_EN, DIV_LAT = 4: `div x10,x1,x2` then `add x11,x10,x0` → ex_hold = 1 for 3 cycles after issue, then qa_sel = 1.
- rst asserted during the second ex_hold cycle → all outputs 0 on the following cycle, records empty.
